led_bank: RTL and testbench
===========================

Name: led_bank

Overview:
- Instruction-driven output peripheral driving an 8-LED bank; the write-side counterpart of the push-button reader.
- Sits on the shared 12-bit instruction bus: `inst[11:8]` is the opcode and `inst[7:0]` is the immediate.
- Holds a static LED pattern plus a per-LED blink mask.
- An internal prescaler toggles a blink phase every BlinkWait cycles; masked LEDs invert their pattern value while the phase is 1.

Parameters:
- BlinkWait, 25000000, cycles per blink half-period (legal range ≥ 2).
- BlinkSize, 32, width of the prescaler counter; must satisfy 2^BlinkSize > BlinkWait.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- inst  in  12  instruction word: [11:8] opcode, [7:0] immediate.
- inst_en  in  1  instruction valid qualifier; inst is ignored when 0.
- leds  out  8  LED drive, registered: pattern ^ (mask & {8{phase}}).
- error  out  1  high while in the Error state, registered.

Behaviour:
- Registers:
  - state (2 bits: Reset=0, Ready=1, Error=2).
  - pattern[7:0], mask[7:0].
  - phase (1 bit).
  - cnt[BlinkSize-1:0].
- Reset:
  - reset=1 at an edge → state=Reset; pattern, mask, phase and cnt all 0.
  - Outputs: leds=0, error=0.
  - Reset has priority over everything and is legal mid-blink or in Error.
- Reset state:
  - Lasts exactly one cycle after reset deasserts, then goes to Ready.
  - inst and inst_en are ignored in this cycle.
  - All registers are held at 0.
- Ready state, prescaler:
  - Runs every cycle.
  - If cnt==BlinkWait-1: cnt←0 and phase←~phase.
  - Otherwise cnt←cnt+1.
- Ready state, instructions (only when inst_en=1):
  - 0x0 NOP: no register change; prescaler runs.
  - 0x1 LDI: pattern←inst[7:0]; prescaler runs.
  - 0x2 LDB: mask←inst[7:0], cnt←0, phase←0. This overrides any prescaler toggle in the same cycle.
  - 0x3 TGL: pattern←pattern ^ inst[7:0]; prescaler runs.
  - 0x4–0xF: state←Error.
- Simultaneous events:
  - LDI or TGL on the same edge as a phase toggle: both take effect.
  - leds after that edge use the new pattern and the new phase.
- Error state:
  - Sticky until reset.
  - pattern, mask, phase and cnt forced to 0, so leds=0; error=1.
  - All instructions are ignored.
- Latency:
  - An instruction sampled at edge k is visible on leds right after edge k (one registered stage).
  - No combinational path from inst to leds.
- Blink timing: with mask≠0, masked LEDs change every BlinkWait cycles; the first toggle comes BlinkWait cycles after the LDB edge.
- Undefined/X opcodes while inst_en=0 have no effect.

Test Plan:
- Reset and startup:
  - Stimulus: reset 3 cycles, then release.
  - Required: leds=0x00 and error=0 throughout.
  - Required: LDI 0xA5 issued in the first post-reset cycle is ignored (leds stay 0x00).
  - Required: LDI 0xA5 one cycle later gives leds=0xA5 on the next edge.
- Blink at BlinkWait=4:
  - Stimulus: LDI 0x0F, then LDB 0x03.
  - Required: leds=0x0F for 4 cycles, then 0x0C for 4, then 0x0F for 4, repeating.
  - Required: a second LDB 0x03 mid-period restarts the phase (leds=0x0F for a full 4 cycles).
- Toggle:
  - Stimulus: LDI 0xF0, then TGL 0xFF.
  - Required: leds=0x0F.
  - Stimulus: TGL 0x0F issued on the exact edge where the phase toggles, with mask=0x01.
  - Required: leds reflects pattern 0x00 ^ 0x01 = 0x01.
- Gating:
  - Stimulus: inst=0x1FF held with inst_en=0 for 10 cycles.
  - Required: leds unchanged.
  - Stimulus: NOP with inst_en=1.
  - Required: leds unchanged.
- Error:
  - Stimulus: opcode 0x7 with inst_en=1.
  - Required: next edge error=1 and leds=0x00; a subsequent LDI 0xFF is ignored.
  - Stimulus: reset, then LDI 0xFF.
  - Required: leds=0xFF and error=0.
- Reset mid-blink:
  - Stimulus: assert reset while phase=1 and mask=0xFF.
  - Required: leds=0x00 on the next edge.
  - Required: after recovery, no blinking until a new LDB is issued.

Source files
------------

// File: rtl/led_bank.sv
// Instruction-driven 8-LED output bank: a static pattern plus a per-LED blink mask
// whose phase is flipped by a free-running prescaler every BlinkWait cycles.
module led_bank #(
  parameter int BlinkWait = 25000000,
  parameter int BlinkSize = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic [7:0]  leds,
  output logic        error
);

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StReady = 2'd1,
    StError = 2'd2
  } state_t;

  localparam logic [BlinkSize-1:0] CntLast = BlinkSize'(BlinkWait - 1);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLdb = 4'h2;
  localparam logic [3:0] OpTgl = 4'h3;

  state_t               r_state;
  state_t               w_stateNext;
  logic [7:0]           r_pattern;
  logic [7:0]           r_mask;
  logic                 r_phase;
  logic [BlinkSize-1:0] r_cnt;
  logic [7:0]           r_leds;
  logic                 r_error;

  logic [7:0]           w_patternNext;
  logic [7:0]           w_maskNext;
  logic                 w_phaseNext;
  logic [BlinkSize-1:0] w_cntNext;
  logic [7:0]           w_ledsNext;
  logic                 w_errorNext;

  logic [3:0]           w_opcode;
  logic [7:0]           w_imm;
  logic                 w_cntWrap;

  assign w_opcode  = inst[11:8];
  assign w_imm     = inst[7:0];
  assign w_cntWrap = (r_cnt == CntLast);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StReset;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      StReset: w_stateNext = StReady;
      StReady: begin
        if (inst_en && (w_opcode > OpTgl)) begin
          w_stateNext = StError;
        end
      end
      StError: w_stateNext = StError;
      default: w_stateNext = StReset;
    endcase
  end

  // Everything stays cleared outside Ready, including on the edge that enters Error.
  always_comb begin
    w_patternNext = 8'h00;
    w_maskNext    = 8'h00;
    w_phaseNext   = 1'b0;
    w_cntNext     = '0;
    if ((r_state == StReady) && (w_stateNext == StReady)) begin
      w_patternNext = r_pattern;
      w_maskNext    = r_mask;
      w_phaseNext   = w_cntWrap ? ~r_phase : r_phase;
      w_cntNext     = w_cntWrap ? '0 : r_cnt + BlinkSize'(1);
      if (inst_en) begin
        case (w_opcode)
          OpNop: ;
          OpLdi: w_patternNext = w_imm;
          OpLdb: begin
            w_maskNext  = w_imm;
            w_cntNext   = '0;
            w_phaseNext = 1'b0;
          end
          OpTgl: w_patternNext = r_pattern ^ w_imm;
          default: ;
        endcase
      end
    end
    w_ledsNext  = w_patternNext ^ (w_maskNext & {8{w_phaseNext}});
    w_errorNext = (w_stateNext == StError);
  end

  // Outputs are registered from the next-state values so an instruction shows up one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pattern <= 8'h00;
      r_mask    <= 8'h00;
      r_phase   <= 1'b0;
      r_cnt     <= '0;
      r_leds    <= 8'h00;
      r_error   <= 1'b0;
    end else begin
      r_pattern <= w_patternNext;
      r_mask    <= w_maskNext;
      r_phase   <= w_phaseNext;
      r_cnt     <= w_cntNext;
      r_leds    <= w_ledsNext;
      r_error   <= w_errorNext;
    end
  end

  assign leds  = r_leds;
  assign error = r_error;

endmodule

// File: tb/tb_led_bank.sv
// Table-driven bench for led_bank with BlinkWait=4; expected outputs are queued as
// each cycle is driven and compared once the registered outputs settle.
module tb_led_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] inst = 12'h000;
  logic        inst_en = 1'b0;
  logic [7:0]  leds;
  logic        error;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [11:0] inst;
    logic [7:0]  expLeds;
    logic        expErr;
    int          repeatN;
    string       name;
  } vec_t;

  typedef struct {
    logic [7:0] leds;
    logic       err;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];

  led_bank #(.BlinkWait(4), .BlinkSize(8)) dut (
    .clock(clock),
    .reset(reset),
    .inst(inst),
    .inst_en(inst_en),
    .leds(leds),
    .error(error)
  );

  always #5 clock = ~clock;

  task automatic addVec(input logic rst, input logic en, input logic [11:0] ins,
                        input logic [7:0] el, input logic ee, input int n, input string nm);
    vec_t v;
    v.rst = rst; v.en = en; v.inst = ins; v.expLeds = el; v.expErr = ee;
    v.repeatN = n; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      bad++;
      total++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = expQ.pop_front();
    total++;
    if (leds !== e.leds) begin
      bad++;
      $display("[TB] FAIL %s leds: got %02h want %02h", e.name, leds, e.leds);
    end
    total++;
    if (error !== e.err) begin
      bad++;
      $display("[TB] FAIL %s error: got %0b want %0b", e.name, error, e.err);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [11:0] ins,
                               input logic [7:0] el, input logic ee, input string nm);
    exp_t e;
    @(negedge clock);
    reset = rst;
    inst_en = en;
    inst = ins;
    e.leds = el; e.err = ee; e.name = nm;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset and startup
    addVec(1, 0, 12'h000, 8'h00, 0, 3, "reset_hold");
    addVec(0, 1, 12'h1A5, 8'h00, 0, 1, "ldi_in_reset_state");
    addVec(0, 1, 12'h1A5, 8'h A5, 0, 1, "ldi_first_ready");
    // Blink: LDB edge starts four phase-0 cycles
    addVec(0, 1, 12'h10F, 8'h0F, 0, 1, "ldi_0f");
    addVec(0, 1, 12'h203, 8'h0F, 0, 1, "ldb_03");
    addVec(0, 0, 12'h000, 8'h0F, 0, 3, "blink_p0_a");
    addVec(0, 0, 12'h000, 8'h0C, 0, 4, "blink_p1_a");
    addVec(0, 0, 12'h000, 8'h0F, 0, 4, "blink_p0_b");
    addVec(0, 0, 12'h000, 8'h0C, 0, 2, "blink_p1_b");
    addVec(0, 1, 12'h203, 8'h0F, 0, 1, "ldb_restart");
    addVec(0, 0, 12'h000, 8'h0F, 0, 3, "restart_full_p0");
    addVec(0, 0, 12'h000, 8'h0C, 0, 1, "restart_p1");
    // Toggle
    addVec(0, 1, 12'h200, 8'h0F, 0, 1, "ldb_00");
    addVec(0, 1, 12'h1F0, 8'hF0, 0, 1, "ldi_f0");
    addVec(0, 1, 12'h3FF, 8'h0F, 0, 1, "tgl_ff");
    addVec(0, 1, 12'h201, 8'h0F, 0, 1, "ldb_01");
    addVec(0, 0, 12'h000, 8'h0F, 0, 3, "wait_toggle");
    addVec(0, 1, 12'h30F, 8'h01, 0, 1, "tgl_on_phase_edge");
    addVec(0, 0, 12'h000, 8'h01, 0, 1, "after_tgl_phase");
    addVec(0, 1, 12'h200, 8'h00, 0, 1, "ldb_00_b");
    addVec(0, 1, 12'h15A, 8'h5A, 0, 1, "ldi_5a");
    // Gating
    addVec(0, 0, 12'h1FF, 8'h5A, 0, 10, "gated_ldi");
    addVec(0, 1, 12'h0FF, 8'h5A, 0, 1, "nop");
    // Error
    addVec(0, 1, 12'h700, 8'h00, 1, 1, "bad_opcode");
    addVec(0, 1, 12'h1FF, 8'h00, 1, 1, "ldi_in_error");
    addVec(1, 0, 12'h000, 8'h00, 0, 1, "reset_from_error");
    addVec(0, 1, 12'h1FF, 8'h00, 0, 1, "ldi_in_reset_state2");
    addVec(0, 1, 12'h1FF, 8'hFF, 0, 1, "ldi_ff_after_error");

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].repeatN; r++) begin
        applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].inst,
                      vecs[i].expLeds, vecs[i].expErr, vecs[i].name);
      end
    end

    // Reset while phase=1 with a full mask, then confirm blinking stays off until a new LDB
    applyStimulus(0, 1, 12'h100, 8'h00, 0, "mid_ldi_00");
    applyStimulus(0, 1, 12'h2FF, 8'h00, 0, "mid_ldb_ff");
    for (int r = 0; r < 3; r++) applyStimulus(0, 0, 12'h000, 8'h00, 0, "mid_p0");
    applyStimulus(0, 0, 12'h000, 8'hFF, 0, "mid_p1_a");
    applyStimulus(0, 0, 12'h000, 8'hFF, 0, "mid_p1_b");
    applyStimulus(1, 0, 12'h000, 8'h00, 0, "mid_reset");
    applyStimulus(0, 1, 12'h13C, 8'h00, 0, "mid_reset_state");
    applyStimulus(0, 1, 12'h13C, 8'h3C, 0, "mid_ldi_3c");
    for (int r = 0; r < 8; r++) applyStimulus(0, 0, 12'h000, 8'h3C, 0, "no_blink_after_reset");
    applyStimulus(0, 1, 12'h2FF, 8'h3C, 0, "new_ldb_ff");
    for (int r = 0; r < 3; r++) applyStimulus(0, 0, 12'h000, 8'h3C, 0, "new_blink_p0");
    applyStimulus(0, 0, 12'h000, 8'hC3, 0, "new_blink_p1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
